cpu_control_unit: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 8-bit processor.
- Fetches instruction bytes over a ready-handshaked memory read port and drives the ALU op code and register write enables.
- Consumes the ALU's registered result, carry and zero outputs, and keeps the architectural Z/C flags used by conditional jumps.
- Sits between program memory and the datapath (A/B registers plus ALU).

---
 rtl/cpu_control_unit_if.sv | 25 ++
 rtl/cpu_control_unit.sv | 134 +++++++++++++
 tb/tb_cpu_control_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_unit_if.sv
// Program-memory read port between the control unit and instruction memory.
// The control unit drives address/request; memory returns data with a ready flag.
interface cpu_control_unit_if #(
    parameter int N      = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [N-1:0]      mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit processor.
// Drives ALU op select and A/B/out write strobes; keeps the Z/C flags.
module cpu_control_unit #(
    parameter int                N        = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_control_unit_if.master  bus,
    input  logic                i_alu_carry,
    input  logic                i_alu_zero,
    output logic [3:0]          o_alu_op,
    output logic                o_a_we,
    output logic                o_b_we,
    output logic                o_a_sel,
    output logic                o_out_we,
    output logic                o_flag_z,
    output logic                o_flag_c,
    output logic                o_halted,
    output logic                o_illegal
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h8;
    localparam logic [3:0] OP_LDB = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_OUT = 4'hD;
    localparam logic [3:0] OP_ILL = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [3:0] ALU_NOP = 4'd7;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPFETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [N-1:0]      r_ir;
    logic              r_flag_z;
    logic              r_flag_c;
    logic              r_halted;
    logic              r_illegal;

    logic [3:0] w_op;
    logic       w_is_alu;
    logic       w_is_two;
    logic       w_take;
    logic       w_opf_rdy;
    logic       w_alu_st;

    assign w_op      = r_ir[N-1 -: 4];
    assign w_is_alu  = (w_op != OP_NOP) && (w_op < OP_LDA);
    assign w_is_two  = (w_op >= OP_LDA) && (w_op <= OP_JC);
    assign w_take    = (w_op == OP_JMP)
                     || ((w_op == OP_JZ) && r_flag_z)
                     || ((w_op == OP_JC) && r_flag_c);
    assign w_opf_rdy = (r_state == S_OPFETCH) && bus.mem_ready;
    assign w_alu_st  = (r_state == S_EXEC) || (r_state == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_ir    <= bus.mem_rdata;
                        r_pc    <= r_pc + 1'b1;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    unique case (1'b1)
                        w_is_alu: r_state <= S_EXEC;
                        w_is_two: r_state <= S_OPFETCH;
                        (w_op == OP_HLT): begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        (w_op == OP_ILL): begin
                            r_illegal <= 1'b1;
                            r_state   <= S_FETCH;
                        end
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_OPFETCH: begin
                    if (bus.mem_ready) begin
                        // A taken jump overrides the operand-byte increment
                        r_pc    <= w_take ? ADDR_W'(bus.mem_rdata)
                                          : r_pc + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_EXEC: r_state <= S_WB;
                S_WB: begin
                    r_flag_z <= i_alu_zero;
                    r_flag_c <= i_alu_carry;
                    r_state  <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign bus.mem_addr = r_pc;
    assign bus.mem_rd   = (r_state == S_FETCH) || (r_state == S_OPFETCH);

    assign o_alu_op  = w_alu_st ? (w_op - 4'd1) : ALU_NOP;
    assign o_a_sel   = w_opf_rdy && (w_op == OP_LDA);
    assign o_a_we    = (r_state == S_WB) || o_a_sel;
    assign o_b_we    = w_opf_rdy && (w_op == OP_LDB);
    assign o_out_we  = (r_state == S_DECODE) && (w_op == OP_OUT);
    assign o_flag_z  = r_flag_z;
    assign o_flag_c  = r_flag_c;
    assign o_halted  = r_halted;
    assign o_illegal = r_illegal;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with memory, A/B/ALU model
// and a scoreboard of expected write-strobe events.
module tb_cpu_control_unit;

    localparam int K_LDA = 0;
    localparam int K_ALU = 1;
    localparam int K_LDB = 2;
    localparam int K_OUT = 3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
        logic [3:0] op;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_control_unit_if #(.N(8), .ADDR_W(8)) bus();

    logic       alu_carry, alu_zero;
    logic [3:0] alu_op;
    logic       a_we, b_we, a_sel, out_we;
    logic       flag_z, flag_c, halted, illegal;

    cpu_control_unit #(.N(8), .ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .i_alu_carry (alu_carry),
        .i_alu_zero  (alu_zero),
        .o_alu_op    (alu_op),
        .o_a_we      (a_we),
        .o_b_we      (b_we),
        .o_a_sel     (a_sel),
        .o_out_we    (out_we),
        .o_flag_z    (flag_z),
        .o_flag_c    (flag_c),
        .o_halted    (halted),
        .o_illegal   (illegal)
    );

    logic [7:0] mem [256];
    logic       ready = 1'b1;
    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.mem_ready = ready;

    logic [7:0] ra, rb, alu_res;
    logic       alu_c, alu_z;
    assign alu_carry = alu_c;
    assign alu_zero  = alu_z;

    function automatic logic [8:0] alu_f(logic [3:0] op, logic [7:0] a,
                                         logic [7:0] b);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a - b};
            4'd2:    return {1'b0, a} + 9'd1;
            4'd3:    return {1'b0, a - 8'd1};
            4'd4:    return {1'b0, a & b};
            4'd5:    return {1'b0, a ^ b};
            4'd6:    return {1'b0, a | b};
            default: return {1'b0, a};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra      <= '0;
            rb      <= '0;
            alu_res <= '0;
            alu_c   <= 1'b0;
            alu_z   <= 1'b0;
        end else begin
            if (a_we) ra <= a_sel ? bus.mem_rdata : alu_res;
            if (b_we) rb <= bus.mem_rdata;
            if (alu_op != 4'd7) begin
                {alu_c, alu_res} <= alu_f(alu_op, ra, rb);
                alu_z <= (alu_f(alu_op, ra, rb) & 9'h0FF) == 9'd0;
            end
        end
    end

    int  n_assert = 0;
    int  n_fail   = 0;
    ev_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input int v, input int op);
        ev_t e;
        e.kind = 2'(k);
        e.val  = 8'(v);
        e.op   = 4'(op);
        q.push_back(e);
    endtask

    logic prev_out = 1'b0;
    always @(negedge clk) begin
        ev_t        e;
        logic [1:0] k;
        logic [7:0] v;
        if (rst_n && (a_we || b_we || out_we)) begin
            chk("one_strobe", 32'(a_we) + 32'(b_we) + 32'(out_we), 1);
            k = out_we ? 2'(K_OUT) : b_we ? 2'(K_LDB)
              : a_sel  ? 2'(K_LDA) : 2'(K_ALU);
            v = out_we ? ra : (b_we || a_sel) ? bus.mem_rdata : alu_res;
            chk("strobe_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ev_kind", 32'(k), 32'(e.kind));
                chk("ev_value", 32'(v), 32'(e.val));
                if (k == 2'(K_ALU)) chk("ev_alu_op", 32'(alu_op), 32'(e.op));
            end
            if (out_we) chk("out_pulse_1cyc", 32'(prev_out), 0);
        end
        prev_out = out_we;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ready = 1'b1;
        q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        @(negedge clk);
    endtask

    task automatic wait_halt(input int max);
        for (int i = 0; i < max && !halted; i++) @(negedge clk);
        chk("halt_reached", 32'(halted), 1);
    endtask

    task automatic wait_addr(input logic [7:0] a, input int max);
        for (int i = 0; i < max && !(bus.mem_rd && bus.mem_addr == a); i++)
            @(negedge clk);
        chk("addr_reached", 32'(bus.mem_addr), 32'(a));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // LDA 05, LDB 03, ADD, HLT
        do_reset();
        mem[0] = 8'h80; mem[1] = 8'h05; mem[2] = 8'h90;
        mem[3] = 8'h03; mem[4] = 8'h10; mem[5] = 8'hF0;
        push(K_LDA, 8'h05, 7);
        push(K_LDB, 8'h03, 7);
        push(K_ALU, 8'h08, 0);
        #1;
        chk("rst_alu_op", 32'(alu_op), 7);
        chk("rst_strobes", 32'({a_we, b_we, out_we}), 0);
        chk("rst_flags", 32'({flag_z, flag_c, halted, illegal}), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lda_cycle3_we", 32'({a_we, a_sel}), 32'h3);
        wait_halt(40);
        chk("p1_flags", 32'({flag_z, flag_c}), 0);
        chk("p1_pc", 32'(bus.mem_addr), 32'h06);
        chk("p1_halt_rd", 32'(bus.mem_rd), 0);
        chk("p1_q_empty", 32'(q.size()), 0);

        // ADD FF+01 -> 00, JZ taken, DEC, JC not taken
        do_reset();
        mem[0] = 8'h80; mem[1] = 8'hFF; mem[2] = 8'h90; mem[3] = 8'h01;
        mem[4] = 8'h10; mem[5] = 8'hB0; mem[6] = 8'h20;
        mem[8'h20] = 8'h40; mem[8'h21] = 8'hC0; mem[8'h22] = 8'h30;
        push(K_LDA, 8'hFF, 7);
        push(K_LDB, 8'h01, 7);
        push(K_ALU, 8'h00, 0);
        push(K_ALU, 8'hFF, 3);
        rst_n = 1'b1;
        wait_addr(8'h20, 40);
        chk("add_flags_zc", 32'({flag_z, flag_c}), 32'h3);
        wait_halt(40);
        chk("jc_fallthru_pc", 32'(bus.mem_addr), 32'h24);
        chk("dec_flags", 32'({flag_z, flag_c}), 0);
        chk("p2_q_empty", 32'(q.size()), 0);

        // Fetch wait states
        do_reset();
        mem[0] = 8'hD0;
        push(K_OUT, 8'h00, 7);
        ready = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wait_rd_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'h100);
            chk("wait_no_strobe", 32'({a_we, b_we, out_we}), 0);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("decode_after_ready", 32'(out_we), 1);
        wait_halt(20);
        chk("p3_pc", 32'(bus.mem_addr), 32'h02);
        chk("p3_q_empty", 32'(q.size()), 0);

        // PC wrap on operand fetch at FF
        do_reset();
        mem[0] = 8'h2A; mem[1] = 8'hA0; mem[2] = 8'hFF; mem[8'hFF] = 8'h80;
        push(K_ALU, 8'h00, 1);
        push(K_LDA, 8'h2A, 7);
        rst_n = 1'b1;
        wait_addr(8'hFF, 40);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_opnd_addr", 32'(bus.mem_addr), 32'h00);
        chk("wrap_lda_we", 32'({a_we, a_sel}), 32'h3);
        @(negedge clk);
        chk("wrap_next_fetch", 32'({bus.mem_rd, bus.mem_addr}), 32'h101);
        chk("wrap_a_val", 32'(ra), 32'h2A);
        chk("sub_flags", 32'({flag_z, flag_c}), 32'h2);
        chk("p4_q_empty", 32'(q.size()), 0);

        // Illegal opcode then OUT, flags preserved
        do_reset();
        mem[0] = 8'h80; mem[1] = 8'hFF; mem[2] = 8'h90; mem[3] = 8'h01;
        mem[4] = 8'h10; mem[5] = 8'hE0; mem[6] = 8'hD0;
        push(K_LDA, 8'hFF, 7);
        push(K_LDB, 8'h01, 7);
        push(K_ALU, 8'h00, 0);
        push(K_OUT, 8'h00, 7);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ill_clear_start", 32'(illegal), 0);
        wait_addr(8'h06, 40);
        chk("ill_set", 32'(illegal), 1);
        wait_halt(20);
        chk("ill_sticky", 32'(illegal), 1);
        chk("ill_flags_kept", 32'({flag_z, flag_c}), 32'h3);
        chk("p5_pc", 32'(bus.mem_addr), 32'h08);
        chk("p5_q_empty", 32'(q.size()), 0);

        // Reset during EXEC of SUB
        do_reset();
        mem[0] = 8'h80; mem[1] = 8'h07; mem[2] = 8'h90;
        mem[3] = 8'h02; mem[4] = 8'h20;
        push(K_LDA, 8'h07, 7);
        push(K_LDB, 8'h02, 7);
        push(K_ALU, 8'h05, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 30 && alu_op != 4'd1; i++) @(negedge clk);
        chk("exec_sub_seen", 32'(alu_op), 1);
        rst_n = 1'b0;
        #1;
        chk("exec_rst_op", 32'(alu_op), 7);
        chk("exec_rst_addr", 32'(bus.mem_addr), 0);
        chk("exec_rst_we", 32'({a_we, b_we, out_we}), 0);
        q.delete();
        push(K_LDA, 8'h07, 7);
        push(K_LDB, 8'h02, 7);
        push(K_ALU, 8'h05, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("exec_refetch", 32'({bus.mem_rd, bus.mem_addr}), 32'h100);
        wait_halt(40);
        chk("sub_result_flags", 32'({flag_z, flag_c}), 0);
        chk("p6_q_empty", 32'(q.size()), 0);

        // Reset during HALT clears flags, illegal, halted
        do_reset();
        mem[0] = 8'hE0; mem[1] = 8'h80; mem[2] = 8'hFF;
        mem[3] = 8'h90; mem[4] = 8'h01; mem[5] = 8'h10;
        push(K_LDA, 8'hFF, 7);
        push(K_LDB, 8'h01, 7);
        push(K_ALU, 8'h00, 0);
        rst_n = 1'b1;
        wait_halt(40);
        chk("pre_rst_state", 32'({flag_z, flag_c, illegal}), 32'h7);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_state", 32'({flag_z, flag_c, halted, illegal}), 0);
        chk("halt_rst_addr", 32'(bus.mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("halt_refetch", 32'({bus.mem_rd, bus.mem_addr}), 32'h100);
        chk("p7_q_empty", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
